// File: rtl/bin_7seg_scan_ctrl.sv
// 12-bit binary to 4-digit BCD (shift-add-3, 12 cycles) with a multiplexed, active-low 7-segment scan.
// Accepts one value per 13 cycles; READY_o drops for the whole conversion and VALID_i is ignored meanwhile.
module bin_7seg_scan_ctrl #(
   parameter int SCAN_DIV = 50000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        CLK_i,
   input  logic        RST_i,
   input  logic [11:0] BIN_i,
   input  logic        VALID_i,
   output logic        READY_o,
   output logic [15:0] BCD_o,
   output logic        DONE_o,
   output logic [6:0]  SEG_o,
   output logic [3:0]  DIG_o
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic {S_IDLE, S_CONV} state_t;

   state_t        state_q;
   logic [11:0]   shift_q, shift_d;
   logic [15:0]   scr_q, scr_d;
   logic [15:0]   adj;
   logic [27:0]   cat;
   logic [3:0]    cnt_q;
   logic [15:0]   bcd_q;
   logic          done_q;

   logic [PW-1:0] presc_q;
   logic [1:0]    idx_q;
   logic [3:0]    dig_q;
   logic [3:0]    nib;
   logic          blank;

   // One double-dabble iteration: correct every nibble, then shift the pair left.
   always_comb begin
      adj = scr_q;
      for (int k = 0; k < 4; k++) begin
         if (scr_q[4*k +: 4] >= 4'd5)
            adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
      end
      cat     = {adj, shift_q} << 1;
      scr_d   = cat[27:12];
      shift_d = cat[11:0];
   end

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (VALID_i) begin
                  shift_q <= BIN_i;
                  scr_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= S_CONV;
               end
            end
            S_CONV: begin
               scr_q   <= scr_d;
               shift_q <= shift_d;
               cnt_q   <= cnt_q + 4'd1;
               if (cnt_q == 4'd11) begin
                  bcd_q   <= scr_d;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Free-running scan, independent of the converter.
   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         presc_q <= '0;
         idx_q   <= '0;
         dig_q   <= 4'b1110;
      end else if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_q <= '0;
         idx_q   <= idx_q + 2'd1;
         dig_q   <= ~(4'b0001 << (idx_q + 2'd1));
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

   always_comb begin
      nib   = bcd_q[4*idx_q +: 4];
      blank = 1'b0;
      if (BLANK_LZ) begin
         case (idx_q)
            2'd1:    blank = (bcd_q[15:4] == 12'd0);
            2'd2:    blank = (bcd_q[15:8] == 8'd0);
            2'd3:    blank = (bcd_q[15:12] == 4'd0);
            default: blank = 1'b0;
         endcase
      end
      if (blank) begin
         SEG_o = 7'b1111111;
      end else begin
         case (nib)
            4'd0:    SEG_o = 7'b1000000;
            4'd1:    SEG_o = 7'b1111001;
            4'd2:    SEG_o = 7'b0100100;
            4'd3:    SEG_o = 7'b0110000;
            4'd4:    SEG_o = 7'b0011001;
            4'd5:    SEG_o = 7'b0010010;
            4'd6:    SEG_o = 7'b0000010;
            4'd7:    SEG_o = 7'b1111000;
            4'd8:    SEG_o = 7'b0000000;
            4'd9:    SEG_o = 7'b0010000;
            default: SEG_o = 7'b1111111;
         endcase
      end
   end

   assign READY_o = (state_q == S_IDLE);
   assign BCD_o   = bcd_q;
   assign DONE_o  = done_q;
   assign DIG_o   = dig_q;

endmodule
